// File: rtl/product_accumulator_if.sv
// Product accumulator bus: upstream product terms in, accumulated result out.
// master = producer/consumer side, slave = the accumulator.
interface product_accumulator_if #(
    parameter int unsigned BIT     = 16,
    parameter int unsigned ACC_EXT = 4,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned PROD_W = 2 * BIT;
    localparam int unsigned ACC_W  = PROD_W + ACC_EXT;

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  term_cnt;
    logic              ovf;

    modport master (
        output clear, in_valid, product, in_last, out_ready,
        input  in_ready, out_valid, acc_out, term_cnt, ovf
    );

    modport slave (
        input  clear, in_valid, product, in_last, out_ready,
        output in_ready, out_valid, acc_out, term_cnt, ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates groups of unsigned product terms and presents each group sum.
// BIT is the upstream multiplier operand width (the lowercase name is a
// reserved word); the accumulator is 2*BIT + ACC_EXT bits wide.
// Build option: define PRODUCT_ACCUMULATOR_SAT_EN to clamp the sum at full
// scale on overflow instead of wrapping; ovf is sticky per group either way.
module product_accumulator #(
    parameter int unsigned BIT     = 16,
    parameter int unsigned ACC_EXT = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    product_accumulator_if.slave  bus
);
    localparam int unsigned PROD_W = 2 * BIT;
    localparam int unsigned ACC_W  = PROD_W + ACC_EXT;
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               accept_c;
    logic [SUM_W-1:0]   sum_c;
    logic               carry_c;

    // Handshake and one-bit-wider sum so the carry out marks overflow.
    assign accept_c = bus.in_valid & in_ready_q;
    assign sum_c    = {1'b0, acc_q} + SUM_W'(bus.product);
    assign carry_c  = sum_c[ACC_W];

    // Next-state, accumulator, counter and overflow logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept_c) begin
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
                        acc_d = (carry_c | ovf_q) ? '1 : sum_c[ACC_W-1:0];
`else
                        acc_d = sum_c[ACC_W-1:0];
`endif
                        ovf_d   = ovf_q | carry_c;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d = bus.in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; in_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d != HOLD);
            out_valid_q <= (state_d == HOLD);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.term_cnt  = cnt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: directed scenarios plus random groups
// checked against a plain-arithmetic reference model of each group sum.
module tb_product_accumulator;
    localparam int unsigned BIT     = 16;
    localparam int unsigned ACC_EXT = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PROD_W  = 2 * BIT;
    localparam int unsigned ACC_W   = PROD_W + ACC_EXT;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    product_accumulator_if #(.BIT(BIT), .ACC_EXT(ACC_EXT), .CNT_W(CNT_W)) pa_if ();

    product_accumulator #(.BIT(BIT), .ACC_EXT(ACC_EXT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pa_if.slave)
    );

    exp_t            sb_q[$];
    int              errors = 0;
    int              checks = 0;
    longint unsigned grp_sum = 0;
    int unsigned     grp_cnt = 0;
    bit              rdy_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a group's result is just the true sum, wrapped or clamped.
    function automatic exp_t model(input longint unsigned sum, input int unsigned n);
        exp_t            e;
        longint unsigned lim;
        int unsigned     cmax;
        lim   = (64'd1 << ACC_W) - 64'd1;
        cmax  = (32'd1 << CNT_W) - 32'd1;
        e.ovf = (sum > lim);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        e.acc = e.ovf ? ACC_W'(lim) : ACC_W'(sum);
`else
        e.acc = ACC_W'(sum % (lim + 64'd1));
`endif
        e.cnt = (n > cmax) ? CNT_W'(cmax) : CNT_W'(n);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one term until it is accepted; record it in the model on acceptance.
    task automatic send(input logic [PROD_W-1:0] p, input logic last);
        int unsigned n;
        bit          done;
        n    = 0;
        done = 1'b0;
        pa_if.in_valid = 1'b1;
        pa_if.product  = p;
        pa_if.in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (pa_if.in_ready === 1'b1 && pa_if.clear === 1'b0) begin
                grp_sum += longint'(p);
                grp_cnt++;
                if (last) begin
                    sb_q.push_back(model(grp_sum, grp_cnt));
                    grp_sum = 0;
                    grp_cnt = 0;
                end
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready stuck at %b for term 0x%0h", pa_if.in_ready, p);
                    done = 1'b1;
                end
            end
            tick();
        end
        pa_if.in_valid = 1'b0;
    endtask

    // Random consumer backpressure unless a directed scenario owns out_ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rdy_force) pa_if.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pop and compare on every result handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (pa_if.out_valid === 1'b1) check("in_ready_low_in_hold", 64'(pa_if.in_ready), 64'd0);
                if (pa_if.out_valid === 1'b1 && pa_if.out_ready === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: acc_out=0x%0h with no expected entry", pa_if.acc_out);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_acc_out", 64'(pa_if.acc_out), 64'(e.acc));
                        check("sb_term_cnt", 64'(pa_if.term_cnt), 64'(e.cnt));
                        check("sb_ovf", 64'(pa_if.ovf), 64'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned nterms;
        int unsigned waited;
        logic [ACC_W-1:0] exp_big;

        pa_if.clear     = 1'b0;
        pa_if.in_valid  = 1'b0;
        pa_if.product   = '0;
        pa_if.in_last   = 1'b0;
        pa_if.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        check("rst_acc_out", 64'(pa_if.acc_out), 64'd0);
        check("rst_term_cnt", 64'(pa_if.term_cnt), 64'd0);
        check("rst_ovf", 64'(pa_if.ovf), 64'd0);
        check("rst_out_valid", 64'(pa_if.out_valid), 64'd0);
        check("rst_in_ready", 64'(pa_if.in_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_reset", 64'(pa_if.in_ready), 64'd1);

        // Basic group 3+5+7 with a ready consumer.
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b1);
        check("basic_out_valid", 64'(pa_if.out_valid), 64'd1);
        check("basic_acc_out", 64'(pa_if.acc_out), 64'd15);
        tick();
        check("basic_back_idle_valid", 64'(pa_if.out_valid), 64'd0);
        check("basic_back_idle_cnt", 64'(pa_if.term_cnt), 64'd0);
        check("basic_back_idle_ready", 64'(pa_if.in_ready), 64'd1);

        // Result held under backpressure while upstream keeps offering.
        pa_if.out_ready = 1'b0;
        send(32'd100, 1'b0);
        send(32'd200, 1'b1);
        pa_if.in_valid = 1'b1;
        pa_if.product  = 32'h55;
        pa_if.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_in_ready", 64'(pa_if.in_ready), 64'd0);
            check("hold_acc_stable", 64'(pa_if.acc_out), 64'd300);
            check("hold_cnt_stable", 64'(pa_if.term_cnt), 64'd2);
        end
        pa_if.in_valid  = 1'b0;
        pa_if.out_ready = 1'b1;
        tick();
        check("hold_release_idle", 64'(pa_if.out_valid), 64'd0);

        // Overflow: 17 full-scale terms.
        for (int i = 0; i < 17; i++) send(32'hFFFF_FFFF, (i == 16));
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        exp_big = 36'hF_FFFF_FFFF;
`else
        exp_big = 36'h0_FFFF_FFEF;
`endif
        check("ovf_acc_out", 64'(pa_if.acc_out), 64'(exp_big));
        check("ovf_flag", 64'(pa_if.ovf), 64'd1);
        check("ovf_term_cnt", 64'(pa_if.term_cnt), 64'd17);
        tick();

        // Clear mid-group with a term on offer, then a fresh group.
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        pa_if.in_valid = 1'b1;
        pa_if.product  = 32'd3;
        pa_if.in_last  = 1'b0;
        pa_if.clear    = 1'b1;
        tick();
        pa_if.clear    = 1'b0;
        pa_if.in_valid = 1'b0;
        grp_sum = 0;
        grp_cnt = 0;
        check("clear_acc_out", 64'(pa_if.acc_out), 64'd0);
        check("clear_term_cnt", 64'(pa_if.term_cnt), 64'd0);
        check("clear_out_valid", 64'(pa_if.out_valid), 64'd0);
        send(32'd9, 1'b1);
        check("after_clear_acc", 64'(pa_if.acc_out), 64'd9);
        tick();

        // Single-term group.
        send(32'hFFFF_0001, 1'b1);
        check("single_acc_out", 64'(pa_if.acc_out), 64'hFFFF_0001);
        check("single_term_cnt", 64'(pa_if.term_cnt), 64'd1);
        check("single_ovf", 64'(pa_if.ovf), 64'd0);
        tick();

        // Asynchronous reset while holding a result: the group is lost.
        pa_if.out_ready = 1'b0;
        send(32'h1234, 1'b1);
        tick();
        check("pre_reset_hold", 64'(pa_if.out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_acc", 64'(pa_if.acc_out), 64'd0);
        check("async_rst_cnt", 64'(pa_if.term_cnt), 64'd0);
        check("async_rst_valid", 64'(pa_if.out_valid), 64'd0);
        check("async_rst_ready", 64'(pa_if.in_ready), 64'd0);
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        #2;
        rst_n = 1'b1;
        pa_if.out_ready = 1'b1;
        tick();
        check("post_reset_ready", 64'(pa_if.in_ready), 64'd1);
        check("post_reset_valid", 64'(pa_if.out_valid), 64'd0);

        // Term counter saturation.
        for (int i = 0; i < 260; i++) send(32'd1, (i == 259));
        tick();

        // Random groups with random backpressure and idle gaps.
        rdy_force = 1'b0;
        for (int g = 0; g < 40; g++) begin
            nterms = (g % 8 == 7) ? 20 : $urandom_range(1, 6);
            for (int i = 0; i < int'(nterms); i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                if (g % 8 == 7) send(32'hF000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF)),
                                     (i == int'(nterms) - 1));
                else            send(32'($urandom()), (i == int'(nterms) - 1));
            end
        end

        // Drain outstanding results.
        rdy_force = 1'b1;
        pa_if.out_ready = 1'b1;
        waited = 0;
        while (sb_q.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still expected", sb_q.size());
        end
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter bit, default 16: operand width of the upstream multiplier; product input is 2*bit wide.
REQ-002 SHALL have parameter ACC_EXT, default 4: guard bits; accumulator width ACC_W = 2*bit + ACC_EXT.
REQ-003 SHALL have parameter CNT_W, default 8: term-counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1: synchronous abort and flush.
REQ-007 SHALL have port in_valid, input, 1: product term offered.
REQ-008 SHALL have port in_ready, output, 1: block can accept a term.
REQ-009 SHALL have port product, input, 2*bit: unsigned product term.
REQ-010 SHALL have port in_last, input, 1: the offered term is the final term of its group.
REQ-011 SHALL have port out_valid, output, 1: accumulated result held.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port acc_out, output, ACC_W: accumulated sum.
REQ-014 SHALL have port term_cnt, output, CNT_W: number of terms accepted in the current group.
REQ-015 SHALL have port ovf, output, 1: sticky overflow flag for the current group.

Function
REQ-016 SHALL implement FSM states IDLE (no partial sum), ACCUM (partial sum held) and HOLD (result presented).
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD, with no same-cycle bypass.
REQ-018 SHALL treat a transfer as accepted on a cycle where in_valid=1 and in_ready=1.
REQ-019 SHALL on an accept do acc += zero-extended product and term_cnt += 1, with term_cnt saturating at 2^CNT_W-1.
REQ-020 SHALL transition to ACCUM on an accept with in_last=0, and to HOLD on an accept with in_last=1.
REQ-021 SHALL make out_valid=1 exactly one cycle after the last term is accepted (latency 1).
REQ-022 SHALL keep acc_out, term_cnt and ovf stable while in HOLD.
REQ-023 SHALL, in HOLD with out_ready=1, go to IDLE next cycle and zero acc, term_cnt and ovf.
REQ-024 SHALL have ovf assert when the true sum exceeds 2^ACC_W-1; ovf stays asserted until the group ends.
REQ-025 SHALL give clear=1 priority over accept and over out_ready: the next state is IDLE, acc, term_cnt and ovf are 0, out_valid is 0, and the offered term is discarded.
REQ-026 SHALL ignore in_valid while in HOLD; the upstream term is not consumed.
REQ-027 SHALL accept a single-term group (in_last=1 on the first term) from IDLE, reaching HOLD with term_cnt=1.
REQ-028 SHALL ignore the value of acc_out when out_valid=0; it nonetheless shows the running partial sum.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force IDLE, acc_out=0, term_cnt=0, ovf=0, out_valid=0 and in_ready=0.
REQ-030 SHALL release in_ready=1 on the first clk edge after rst_n deasserts.
REQ-031 SHALL, on reset asserted mid-group or in HOLD, lose the group without emitting a partial result.

Configuration
REQ-032 SHALL use macro PRODUCT_ACCUMULATOR_SAT_EN; when it is defined, an overflowing add clamps acc to 2^ACC_W-1, holds it there for the rest of the group, and sets ovf=1.
REQ-033 SHALL, when PRODUCT_ACCUMULATOR_SAT_EN is not defined, make acc wrap modulo 2^ACC_W on overflow and set ovf=1; all other behaviour is identical in both builds.

Verification (bit=16, ACC_EXT=4, CNT_W=8)
REQ-034 SHALL cover: terms 3, 5, 7 (last on 7) with out_ready=1 -> out_valid=1 the cycle after 7, acc_out=15, term_cnt=3, ovf=0, then IDLE.
REQ-035 SHALL cover: result held with out_ready=0 for 5 cycles while in_valid=1 -> acc_out stable, in_ready=0, no term consumed; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover: 17 terms of 0xFFFFFFFF -> wrap build gives acc_out=0x0FFFFFFEF, ovf=1; SAT_EN build gives acc_out=0xFFFFFFFFF, ovf=1; term_cnt=17 in both.
REQ-037 SHALL cover: clear asserted with in_valid=1 after 2 of 4 terms -> IDLE, acc_out=0, term_cnt=0; a new group of 9 (last) -> acc_out=9.
REQ-038 SHALL cover: rst_n pulsed low mid-cycle while in HOLD -> outputs zero immediately without waiting for clk, out_valid=0, in_ready=1 one edge after release.
REQ-039 SHALL cover: single term 0xFFFF0001 with in_last=1 -> acc_out=0xFFFF0001, term_cnt=1, ovf=0.
